// File: rtl/event_pkg.sv
// Shared types and constants for the event qualifier front-end.
package event_pkg;

   typedef enum logic [1:0] {
      ST_LOW     = 2'd0,
      ST_QUAL_HI = 2'd1,
      ST_HIGH    = 2'd2,
      ST_QUAL_LO = 2'd3
   } qual_state_t;

   localparam int unsigned           GLITCH_CNT_W   = 8;
   localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = 8'hFF;

   function automatic logic [GLITCH_CNT_W-1:0] glitch_sat_inc(
      input logic [GLITCH_CNT_W-1:0] i_val
   );
      return (i_val == GLITCH_CNT_MAX) ? i_val : i_val + 1'b1;
   endfunction

endpackage

// File: rtl/event_qualifier_if.sv
// Signal bundle between the raw event source and the qualifier.
interface event_qualifier_if;
   import event_pkg::*;

   logic                    i_raw_in;
   logic                    i_enable;
   logic                    o_event;
   logic                    o_level;
   logic [GLITCH_CNT_W-1:0] o_glitch_count;

   modport master (
      output i_raw_in,
      output i_enable,
      input  o_event,
      input  o_level,
      input  o_glitch_count
   );

   modport slave (
      input  i_raw_in,
      input  i_enable,
      output o_event,
      output o_level,
      output o_glitch_count
   );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with asynchronous active-low reset.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule

// File: rtl/event_qualifier.sv
// Synchronise, debounce and edge-qualify a raw input into a one-cycle event pulse.
// Optional glitch counter enabled by defining EVENT_QUALIFIER_GLITCH_CNT_EN.
module event_qualifier
   import event_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic          clk,
   input  logic          reset,
   event_qualifier_if.slave bus
);

   localparam logic [CNT_W-1:0] L_DB = CNT_W'(DEBOUNCE_CYCLES);

   logic              w_s2;
   qual_state_t       r_state;
   qual_state_t       w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_rise;
   logic              w_fall;
   logic              r_event;
   logic              r_level;

   sync_2ff #(
      .WIDTH (1)
   ) u_sync (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_d     (bus.i_raw_in),
      .o_q     (w_s2)
   );

   assign w_cnt_inc = r_cnt + 1'b1;

   // The stable states share the qualifying step so DEBOUNCE_CYCLES=1 skips the QUAL states.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rise      = 1'b0;
      w_fall      = 1'b0;
      unique case (r_state)
         ST_LOW, ST_QUAL_HI: begin
            if (!w_s2) begin
               w_state_nxt = ST_LOW;
               w_cnt_nxt   = '0;
            end else if (w_cnt_inc >= L_DB) begin
               w_state_nxt = ST_HIGH;
               w_cnt_nxt   = '0;
               w_rise      = 1'b1;
            end else begin
               w_state_nxt = ST_QUAL_HI;
               w_cnt_nxt   = w_cnt_inc;
            end
         end
         ST_HIGH, ST_QUAL_LO: begin
            if (w_s2) begin
               w_state_nxt = ST_HIGH;
               w_cnt_nxt   = '0;
            end else if (w_cnt_inc >= L_DB) begin
               w_state_nxt = ST_LOW;
               w_cnt_nxt   = '0;
               w_fall      = 1'b1;
            end else begin
               w_state_nxt = ST_QUAL_LO;
               w_cnt_nxt   = w_cnt_inc;
            end
         end
         default: begin
            w_state_nxt = ST_LOW;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_LOW;
         r_cnt   <= '0;
         r_event <= 1'b0;
         r_level <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_event <= w_rise & bus.i_enable;
         if (w_rise) begin
            r_level <= 1'b1;
         end else if (w_fall) begin
            r_level <= 1'b0;
         end
      end
   end

   assign bus.o_event = r_event;
   assign bus.o_level = r_level;

`ifdef EVENT_QUALIFIER_GLITCH_CNT_EN
   logic                    w_abort;
   logic [GLITCH_CNT_W-1:0] r_glitch_cnt;

   assign w_abort = ((r_state == ST_QUAL_HI) && !w_s2) ||
                    ((r_state == ST_QUAL_LO) &&  w_s2);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_glitch_cnt <= '0;
      end else if (w_abort) begin
         r_glitch_cnt <= glitch_sat_inc(r_glitch_cnt);
      end
   end

   assign bus.o_glitch_count = r_glitch_cnt;
`else
   assign bus.o_glitch_count = '0;
`endif

endmodule

// File: tb/tb_event_qualifier.sv
// Directed bench for event_qualifier at DEBOUNCE_CYCLES=4 and DEBOUNCE_CYCLES=1.
module tb_event_qualifier;

   logic clk;
   logic rst_n;

   int errors = 0;
   int checks = 0;

   int idx, ev4, ev1, first4, first1, consec;
   logic prev4, prev1, lvl_seen4;

   event_qualifier_if b4 ();
   event_qualifier_if b1 ();

   event_qualifier #(.DEBOUNCE_CYCLES(4)) u_dut4 (.clk(clk), .reset(rst_n), .bus(b4));
   event_qualifier #(.DEBOUNCE_CYCLES(1)) u_dut1 (.clk(clk), .reset(rst_n), .bus(b1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int gx(input int n);
`ifdef EVENT_QUALIFIER_GLITCH_CNT_EN
      return n;
`else
      return 0;
`endif
   endfunction

   task automatic drive(input logic raw, input logic en);
      b4.i_raw_in = raw;
      b1.i_raw_in = raw;
      b4.i_enable = en;
      b1.i_enable = en;
   endtask

   task automatic clr();
      idx = 0; ev4 = 0; ev1 = 0; first4 = -1; first1 = -1;
      prev4 = 1'b0; prev1 = 1'b0; lvl_seen4 = 1'b0;
   endtask

   // Sample index i is taken after rising edge i (edge 0 = first capture by s1).
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (b4.o_event === 1'b1) begin
            ev4++;
            if (first4 < 0) first4 = idx;
            if (prev4) consec++;
         end
         if (b1.o_event === 1'b1) begin
            ev1++;
            if (first1 < 0) first1 = idx;
            if (prev1) consec++;
         end
         prev4 = b4.o_event;
         prev1 = b1.o_event;
         lvl_seen4 = lvl_seen4 | b4.o_level;
         idx++;
      end
   endtask

   initial begin
      consec = 0;
      rst_n = 1'b0;
      drive(1'b0, 1'b1);
      clr();
      run(2);
      check("rst_event", int'(b4.o_event), 0);
      check("rst_level", int'(b4.o_level), 0);
      check("rst_glitch", int'(b4.o_glitch_count), 0);
      rst_n = 1'b1;
      run(10);

      // Clean rising edge
      clr();
      drive(1'b1, 1'b1);
      run(5);
      check("clean_lvl_pre", int'(b4.o_level), 0);
      check("clean_d1_lvl", int'(b1.o_level), 1);
      run(1);
      check("clean_lvl_post", int'(b4.o_level), 1);
      check("clean_evt_edge5", int'(b4.o_event), 1);
      run(14);
      check("clean_ev4", ev4, 1);
      check("clean_first4", first4, 5);
      check("clean_first1", first1, 2);
      check("clean_ev1", ev1, 1);
      check("clean_glitch", int'(b4.o_glitch_count), 0);
      drive(1'b0, 1'b1);
      run(10);
      check("fall_level", int'(b4.o_level), 0);

      // Bounce 1,0,1,0 then hold 1
      clr();
      drive(1'b1, 1'b1); run(1);
      drive(1'b0, 1'b1); run(1);
      drive(1'b1, 1'b1); run(1);
      drive(1'b0, 1'b1); run(1);
      drive(1'b1, 1'b1); run(15);
      check("bounce_ev4", ev4, 1);
      check("bounce_ev1", ev1, 3);
      check("bounce_glitch", int'(b4.o_glitch_count), gx(2));
      drive(1'b0, 1'b1);
      run(10);

      // Short pulse rejection
      clr();
      drive(1'b1, 1'b1); run(3);
      drive(1'b0, 1'b1); run(12);
      check("short_ev4", ev4, 0);
      check("short_lvl", int'(lvl_seen4), 0);
      check("short_ev1", ev1, 1);
      check("short_glitch", int'(b4.o_glitch_count), gx(3));

      // Enable gating
      clr();
      drive(1'b1, 1'b0); run(10);
      check("gate_lvl", int'(b4.o_level), 1);
      check("gate_ev4", ev4, 0);
      check("gate_ev1", ev1, 0);
      drive(1'b1, 1'b1); run(6);
      check("gate_reen_ev4", ev4, 0);
      drive(1'b0, 1'b1); run(10);
      check("gate_fall_lvl", int'(b4.o_level), 0);
      drive(1'b1, 1'b1); run(10);
      check("gate_rise_ev4", ev4, 1);
      check("gate_rise_ev1", ev1, 1);
      drive(1'b0, 1'b1); run(10);

      // Three clean 10-cycle pulses
      clr();
      for (int p = 0; p < 3; p++) begin
         drive(1'b1, 1'b1); run(10);
         drive(1'b0, 1'b1); run(10);
      end
      check("chain_ev4", ev4, 3);
      check("chain_ev1", ev1, 3);
      check("no_consecutive", consec, 0);

      // Asynchronous reset while HIGH
      drive(1'b1, 1'b1); run(10);
      check("pre_rst_lvl", int'(b4.o_level), 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_lvl", int'(b4.o_level), 0);
      check("async_rst_glitch", int'(b4.o_glitch_count), 0);
      run(2);
      rst_n = 1'b1;
      drive(1'b0, 1'b1);
      run(10);

      // Reset mid-qualification, release with raw_in high
      clr();
      drive(1'b1, 1'b1); run(4);
      rst_n = 1'b0;
      #1;
      check("midq_rst_evt", int'(b4.o_event), 0);
      check("midq_rst_lvl", int'(b4.o_level), 0);
      run(2);
      clr();
      rst_n = 1'b1;
      run(20);
      check("rel_first4", first4, 5);
      check("rel_ev4", ev4, 1);
      check("rel_first1", first1, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/event_qualifier.md
# event_qualifier

Front-end conditioning stage that turns a raw, asynchronous, possibly bouncing input into a clean single-cycle `event` pulse for the downstream `event_counter`. The stage does four things in order. It synchronises the input, debounces it with a programmable stable-time, tracks the debounced level, and emits one pulse per qualified rising edge. Its `event` output connects directly to `event_counter.event`, and both blocks share the same `enable`.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised samples at the new level required to accept a transition. Legal range is ≥1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of the stability counter.
- `clk  input  1`: single clock. Everything is on the rising edge.
- `reset  input  1`: asynchronous, active-low. 0 = in reset.
- `raw_in  input  1`: asynchronous raw event source, may glitch or bounce.
- `enable  input  1`: 1 = pulses allowed on `event`. 0 = pulses suppressed.
- `event  output  1`: one-cycle pulse on each qualified rising edge, registered.
- `level  output  1`: debounced level, registered.
- `glitch_count  output  8`: saturating count of rejected transitions.

## Operation
- Synchroniser: two flops `s1 -> s2`. Only `s2` feeds the logic.
- FSM states:
  - `LOW`: stable 0.
  - `QUAL_HI`: candidate 1.
  - `HIGH`: stable 1.
  - `QUAL_LO`: candidate 0.
- Transitions:
  - `LOW`, `s2=1` -> `QUAL_HI`, cnt=1.
  - `QUAL_HI`, `s2=1` -> cnt+1. When cnt reaches `DEBOUNCE_CYCLES` -> `HIGH`, `level`=1, `event`=`enable`.
  - `QUAL_HI`, `s2=0` -> `LOW`, cnt=0, glitch detected.
  - `HIGH` / `QUAL_LO` mirror the above. Entering `LOW` from `QUAL_LO` sets `level`=0 and generates no pulse.
- With `DEBOUNCE_CYCLES`=1, the state goes `LOW -> HIGH` on the first `s2=1` sample, and the QUAL states are transient.
- `event` is the registered decision: high for exactly one cycle and never two consecutive cycles.
- `enable`=0:
  - `event` held 0.
  - FSM and `level` keep tracking.
  - Re-asserting `enable` while `level`=1 produces no pulse.
  - `enable` is sampled in the same cycle the accept decision is made.
- Counter never exceeds `DEBOUNCE_CYCLES`. No wrap.
- Reset values: state `LOW`, cnt 0, `s1`/`s2` 0, `event` 0, `level` 0, `glitch_count` 0.
- Reset mid-operation aborts any qualification immediately.
- If `raw_in` is 1 at reset release, it qualifies normally and pulses once.

## Timing
- Edge 0 is the first rising edge at which `s1` captures the new `raw_in` value.
- Latency: `event`/`level` update at edge `DEBOUNCE_CYCLES+1`.
  - With the default of 4, `event` is high between edge 5 and edge 6.
- Minimum accepted pulse width: `DEBOUNCE_CYCLES` cycles high. Minimum spacing between events: `2*DEBOUNCE_CYCLES` cycles.
- A deassertion that reaches `s2` in the same cycle the count would complete counts as a glitch. No event is produced.
- No combinational path from any input to any output.

## Configuration
- `EVENT_QUALIFIER_GLITCH_CNT_EN`, defined:
  - Every abort from `QUAL_HI` or `QUAL_LO` increments `glitch_count`.
  - The count saturates at 255.
  - It is cleared only by `reset`.
- Not defined: `glitch_count` is tied to 0 and the counter flops are not generated.
- The port is present in both builds.

## Structure
- Shared package `event_pkg`:
  - FSM state enum `qual_state_t`, 2 bits.
  - `GLITCH_CNT_W = 8`.
  - `GLITCH_CNT_MAX = 8'hFF`.
- One natural sub-module: `sync_2ff` (generic two-flop synchroniser with async active-low reset). Keeps the CDC boundary isolated for lint waivers.
- FSM, stability counter and glitch counter stay in the top module.

## Test plan
- Clean rising edge: `raw_in` 0->1 held 20 cycles, `enable`=1, default params -> `event` high exactly one cycle at edge 5, `level`=1 from edge 5, `glitch_count`=0.
- Bounce: `raw_in` toggles 1,0,1,0 at 1-cycle spacing, then holds 1 -> exactly one `event`. With the macro defined, `glitch_count`=2 (two aborts from `QUAL_HI` once synchronised).
- Enable gating: `enable`=0, `raw_in` rises and holds -> `level`=1 and `event` stays 0. Raise `enable` -> still no pulse. Drop and re-raise `raw_in` for 10 cycles each -> one pulse.
- Short pulse rejection: `raw_in` high for 3 cycles with `DEBOUNCE_CYCLES`=4 -> no `event`, `level` stays 0.
- Reset mid-qualification: assert `reset`=0 at cycle 3 of `QUAL_HI` -> `event`/`level`/cnt 0 asynchronously. Release with `raw_in`=1 -> one pulse after the full latency.
- Chain with `event_counter`: three clean 10-cycle pulses on `raw_in`, `enable`=1 -> `count`=3.
